// File: rtl/block_drawer.sv
// Pixel-stream block renderer: erases the previous block, then draws the new one, one pixel per clock.
// Optional macro BLOCK_DRAWER_ERASE_EN enables the erase pass; without it old blocks remain on screen.
module block_drawer #(
  parameter int          BLOCK_W   = 16,
  parameter int          BLOCK_H   = 4,
  parameter int          X_MAX     = 159,
  parameter int          Y_MAX     = 119,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int CW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int RW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(BLOCK_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(BLOCK_H - 1);
  localparam logic [8:0]    X_LIM    = 9'(X_MAX);
  localparam logic [7:0]    Y_LIM    = 8'(Y_MAX);

`ifdef BLOCK_DRAWER_ERASE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ERASE = 2'd1, S_DRAW = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd2, S_DONE = 2'd3} state_t;
`endif

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [7:0]      r_new_x, r_old_x;
  logic [6:0]      r_new_y, r_old_y;
  logic [2:0]      r_new_col;
  logic            r_prev_valid;
  logic [7:0]      r_vga_x;
  logic [6:0]      r_vga_y;
  logic [2:0]      r_vga_colour;
  logic            r_plot, r_busy, r_done;

  logic            w_active, w_last, w_plot;
  logic [7:0]      w_sel_x;
  logic [6:0]      w_sel_y;
  logic [2:0]      w_colour;
  logic [8:0]      w_col_sum;
  logic [7:0]      w_row_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef BLOCK_DRAWER_ERASE_EN
          w_state_nxt = r_prev_valid ? S_ERASE : S_DRAW;
`else
          w_state_nxt = S_DRAW;
`endif
        end
      end
`ifdef BLOCK_DRAWER_ERASE_EN
      S_ERASE: if (w_last) w_state_nxt = S_DRAW;
`endif
      S_DRAW:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next pixel: sums are one bit wider than the screen coordinates so clipping sees no wrap
  always_comb begin
    w_active = (r_state == S_DRAW);
    w_sel_x  = r_new_x;
    w_sel_y  = r_new_y;
    w_colour = r_new_col;
`ifdef BLOCK_DRAWER_ERASE_EN
    if (r_state == S_ERASE) begin
      w_active = 1'b1;
      w_sel_x  = r_old_x;
      w_sel_y  = r_old_y;
      w_colour = BG_COLOUR;
    end
`endif
    w_col_sum = {1'b0, w_sel_x} + 9'(r_col);
    w_row_sum = {1'b0, w_sel_y} + 8'(r_row);
    w_plot    = w_active && (w_col_sum <= X_LIM) && (w_row_sum <= Y_LIM);
    w_last    = (r_col == COL_LAST) && (r_row == ROW_LAST);
  end

`ifndef BLOCK_DRAWER_ERASE_EN
  logic w_unused_erase;
  assign w_unused_erase = ^{r_prev_valid, r_old_x, r_old_y, BG_COLOUR};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_new_x      <= '0;
      r_new_y      <= '0;
      r_new_col    <= '0;
      r_old_x      <= '0;
      r_old_y      <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_new_x   <= x_in;
        r_new_y   <= y_in;
        r_new_col <= colour_in;
        r_col     <= '0;
        r_row     <= '0;
      end else if (w_active) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (r_state == S_DONE) begin
        r_old_x      <= r_new_x;
        r_old_y      <= r_new_y;
        r_prev_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_plot <= w_plot;
      r_busy <= w_active;
      r_done <= (r_state == S_DONE);
      if (w_active) begin
        r_vga_x      <= w_col_sum[7:0];
        r_vga_y      <= w_row_sum[6:0];
        r_vga_colour <= w_colour;
      end
    end
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign plot       = r_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_block_drawer.sv
// Self-checking bench for block_drawer: a pixel-list model of each redraw is compared cycle by cycle.
module tb_block_drawer;

  localparam int W = 16;
  localparam int H = 4;
`ifdef BLOCK_DRAWER_ERASE_EN
  localparam bit ERASE_EN = 1'b1;
`else
  localparam bit ERASE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_prev_valid = 1'b0;
  int m_old_x = 0;
  int m_old_y = 0;

  always #5 clk = ~clk;

  block_drawer dut (
    .clk(clk), .reset(reset), .start(start),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .done(done)
  );

  // Expected output word {plot, busy, done, x, y, colour} for one scanned pixel
  function automatic logic [20:0] pix(input int x, input int y, input logic [2:0] c);
    logic vis;
    vis = (x <= 159) && (y <= 119);
    return {vis, 1'b1, 1'b0, 8'(x), 7'(y), c};
  endfunction

  function automatic logic [20:0] outs();
    return {plot, busy, done, vga_x, vga_y, vga_colour};
  endfunction

  task automatic scramble_inputs();
    x_in      = 8'($urandom);
    y_in      = 7'($urandom);
    colour_in = 3'($urandom);
  endtask

  task automatic run_redraw(input string name, input logic [7:0] nx, input logic [6:0] ny,
                            input logic [2:0] nc, input int inj_draw);
    logic [20:0] exp_q[$];
    logic [20:0] got;
    int n_erase;
    int inj;
    n_erase = 0;
    if (ERASE_EN && m_prev_valid) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          exp_q.push_back(pix(m_old_x + c, m_old_y + r, 3'b000));
      n_erase = W * H;
    end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back(pix(int'(nx) + c, int'(ny) + r, nc));
    inj = (inj_draw > 0) ? n_erase + inj_draw : -1;

    x_in = nx; y_in = ny; colour_in = nc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    for (int k = 1; k <= exp_q.size(); k++) begin
      if (k == inj) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      scramble_inputs();
      got = outs();
      n_checks++;
      if (got !== exp_q[k-1]) begin
        n_fail++;
        $display("FAIL %s pixel %0d: got {plot,busy,done,x,y,col}=%h, expected %h", name, k, got, exp_q[k-1]);
      end
    end
    @(posedge clk); #1;
    got = outs();
    n_checks++;
    if (got[20:18] !== 3'b001) begin
      n_fail++;
      $display("FAIL %s done cycle %0d: got {plot,busy,done}=%b, expected 001", name, exp_q.size() + 1, got[20:18]);
    end
    @(posedge clk); #1;
    got = outs();
    n_checks++;
    if (got[20:18] !== 3'b000) begin
      n_fail++;
      $display("FAIL %s idle after done: got {plot,busy,done}=%b, expected 000", name, got[20:18]);
    end
    m_prev_valid = 1'b1;
    m_old_x = int'(nx);
    m_old_y = int'(ny);
  endtask

  task automatic test_reset();
    logic [20:0] got;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    got = outs();
    n_checks++;
    if (got !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_held: got outputs %h, expected 0", got);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    got = outs();
    n_checks++;
    if (got !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_released_idle: got outputs %h, expected 0", got);
    end
    m_prev_valid = 1'b0;
  endtask

  task automatic test_first_draw();
    run_redraw("first_draw", 8'd10, 7'd20, 3'b100, 0);
  endtask

  task automatic test_erase_redraw();
    run_redraw("erase_redraw", 8'd40, 7'd20, 3'b010, 0);
  endtask

  task automatic test_clipping();
    run_redraw("clip_corner", 8'd150, 7'd118, 3'b111, 0);
    run_redraw("clip_far", 8'd250, 7'd125, 3'b011, 0);
  endtask

  task automatic test_ignored_start();
    run_redraw("ignored_start", 8'd60, 7'd50, 3'b101, 10);
  endtask

  task automatic test_reset_midscan();
    logic [20:0] got;
    x_in = 8'd30; y_in = 7'd40; colour_in = 3'b110; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    got = outs();
    n_checks++;
    if (got !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_midscan_async: got outputs %h, expected 0", got);
    end
    @(negedge clk);
    reset = 1'b0;
    m_prev_valid = 1'b0;
    @(posedge clk); #1;
    run_redraw("after_reset", 8'($urandom_range(0, 150)), 7'($urandom_range(0, 115)), 3'b001, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++)
      run_redraw("random", 8'($urandom), 7'($urandom), 3'($urandom_range(1, 7)), (i == 2) ? 30 : 0);
  endtask

  task automatic test_back_to_back();
    run_redraw("back_to_back_a", 8'd0, 7'd0, 3'b011, 0);
    run_redraw("back_to_back_b", 8'd144, 7'd116, 3'b110, 0);
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_erase_redraw();
    test_clipping();
    test_ignored_start();
    test_reset_midscan();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_drawer.md
# block_drawer

Pixel-stream renderer between `game_logic_top` and the VGA adapter. For each `start` pulse it latches the current block position and colour from the game logic. It erases the block drawn on the previous update by painting it in background colour, then draws the block at the new position. Output is one pixel write per clock on the adapter's `x`/`y`/`colour`/`plot` interface.

## Interface
- `BLOCK_W`, 16: block width in pixels (power of two, 2..32)
- `BLOCK_H`, 4: block height in pixels (power of two, 1..16)
- `X_MAX`, 159: last visible column
- `Y_MAX`, 119: last visible row
- `BG_COLOUR`, 3'b000: erase colour

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain)
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to redraw; sampled only in IDLE
- `x_in`  in  8  top-left column of new block
- `y_in`  in  7  top-left row of new block
- `colour_in`  in  3  block colour
- `vga_x`  out  8  pixel column (registered)
- `vga_y`  out  7  pixel row (registered)
- `vga_colour`  out  3  pixel colour (registered)
- `plot`  out  1  pixel write strobe (registered)
- `busy`  out  1  high in ERASE and DRAW
- `done`  out  1  one-cycle pulse when a redraw completes

## Operation
- Reset:
  - all outputs clear to 0.
  - State goes to IDLE.
  - `prev_valid` clears to 0.
  - Latched old and new positions clear to 0.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - `start`=1 latches `x_in`/`y_in`/`colour_in` into new_x/new_y/new_col.
  - Column and row counters clear.
  - Next state is ERASE if `prev_valid`=1, otherwise DRAW.
- ERASE:
  - Scans old_x+col, old_y+row with col as the inner loop, one pixel per cycle.
  - Colour is `BG_COLOUR`.
  - After col=BLOCK_W-1 and row=BLOCK_H-1, the counters clear and the state goes to DRAW.
- DRAW:
  - Same scan over new_x/new_y with colour new_col.
  - After the last pixel the state goes to DONE.
- DONE:
  - old_x/old_y take new_x/new_y and `prev_valid` sets.
  - `done`=1 for this cycle only.
  - Next state is IDLE.
- Address arithmetic:
  - Column sum is computed 9 bits wide and row sum 8 bits wide, so there is no wrap.
  - A pixel with column sum > `X_MAX` or row sum > `Y_MAX` is clipped: `plot`=0 for that cycle and the scan continues.
  - `vga_x`/`vga_y` carry the low bits of the sums regardless of clipping.
- `start` outside IDLE is ignored; it is not queued.
- `x_in`/`y_in`/`colour_in` are not sampled except on an accepted `start`.
- Reset asserted mid-scan aborts immediately. `plot` drops asynchronously and `prev_valid`=0, so the next redraw does not erase.

## Timing
- An accepted `start` at edge N produces the first pixel (`plot`=1) registered at edge N+1.
- With `prev_valid`=1, ERASE occupies N+1..N+BLOCK_W·BLOCK_H.
- DRAW occupies the next BLOCK_W·BLOCK_H cycles.
- `done` is high for 1 cycle after the last DRAW pixel. Total `start`-to-`done` latency is 2·W·H+1 cycles (W·H+1 without erase).
- `busy` is high exactly while `plot` is being generated (ERASE/DRAW), including clipped cycles.
- A new `start` is earliest accepted in the IDLE cycle following `done`.
- `vga_x`, `vga_y`, `vga_colour` and `plot` change together on the same edge; there is no combinational path from inputs to outputs.

## Configuration
- `BLOCK_DRAWER_ERASE_EN`
  - Defined: ERASE phase behaves as above.
  - Undefined: ERASE state is not compiled. IDLE always goes to DRAW, previous blocks remain on screen (stack trail), and latency is W·H+1 cycles. `prev_valid` and old_x/old_y are still maintained but unused.

## Test plan
- Reset, then `start` with x_in=8'd10, y_in=7'd20, colour_in=3'b100 → 64 `plot` cycles covering x 10..25, y 20..23 row-major, colour 100. `done` is high at cycle 65 after `start`, with no erase.
- Second `start` with x=40, y=20, colour=3'b010 → 64 erase pixels at x 10..25 with colour 000, then 64 draw pixels at x 40..55. `done` is high at cycle 129.
- `start` with x=150, y=118 → pixels with x>159 or y>119 have `plot`=0. The 20 visible pixels (x 150..159, y 118..119) are plotted. `busy` holds for 64 cycles and `done` timing is unchanged.
- `start` pulsed again 10 cycles into a DRAW → ignored: pixel sequence, colour and `done` cycle are unchanged.
- Reset asserted during ERASE → `plot`, `busy` and `done` go to 0 immediately. The next `start` goes straight to DRAW with latency 65.
- With `BLOCK_DRAWER_ERASE_EN` undefined → the second redraw emits only 64 draw pixels, and `done` comes 65 cycles after `start`.
